// File: rtl/toggle_event_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : toggle_event_pkg
// Purpose  : Shared types and helpers for the toggle-encoded event transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package toggle_event_pkg;

  // Transmit FSM: IDLE has no hold window running, HOLD spaces out toggles.
  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_HOLD = 1'b1
  } tx_state_t;

  // Hold counter width: enough bits for HOLD_CYCLES-1, never less than one.
  function automatic int hold_cnt_w(input int hold_cycles);
    return (hold_cycles <= 2) ? 1 : $clog2(hold_cycles);
  endfunction

endpackage : toggle_event_pkg
`default_nettype wire

// File: rtl/toggle_event_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : toggle_event_tx_if
// Purpose  : Event handshake plus encoded level line of the transmitter.
//            master = event source / observer, slave = transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface toggle_event_tx_if #(
  parameter int PEND_W = 4
);

  logic              ev_valid;
  logic              ev_ready;
  logic              sig_out;
  logic              busy;
  logic [PEND_W-1:0] pending;

  modport master (
    output ev_valid,
    input  ev_ready,
    input  sig_out,
    input  busy,
    input  pending
  );

  modport slave (
    input  ev_valid,
    output ev_ready,
    output sig_out,
    output busy,
    output pending
  );

endinterface : toggle_event_tx_if
`default_nettype wire

// File: rtl/toggle_event_tx_hold_timer.sv
`default_nettype none
// ============================================================================
// Module   : hold_timer
// Purpose  : Down-counter that measures the minimum spacing between toggles.
//            'load' restarts the window at HOLD_CYCLES-1; 'expired' is high
//            once the count has reached zero.
// Revision : 1.0 - initial release
// ============================================================================
module hold_timer
  import toggle_event_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  load,
  output logic expired
);

  localparam int                 c_CNT_W  = hold_cnt_w(HOLD_CYCLES);
  localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(HOLD_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // Reload on a toggle, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= c_RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_CNT_W'(1);
    end
  end

  assign expired = (r_cnt == '0);

endmodule : hold_timer
`default_nettype wire

// File: rtl/toggle_event_tx.sv
`default_nettype none
// ============================================================================
// Module   : toggle_event_tx
// Purpose  : Converts discrete events into single toggles of a level line,
//            spacing toggles at least HOLD_CYCLES clocks apart and queueing
//            early events in a saturating pending counter.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_event_tx
  import toggle_event_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int PEND_W      = 4
) (
  input  wire                      clk,
  input  wire                      rst,
  toggle_event_tx_if.slave         bus
);

  localparam logic [PEND_W-1:0] c_PEND_FULL = {PEND_W{1'b1}};

  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic [PEND_W-1:0] r_pending;
  logic              r_sig;
  logic              w_emit;
  logic              w_accept;
  logic              w_expired;
  logic              w_ready;
  logic              w_has_pend;

  // Readiness depends on the registered counter only, so there is no
  // combinational path from ev_valid back to ev_ready.
  assign w_ready    = (r_pending != c_PEND_FULL);
  assign w_has_pend = (r_pending != '0);
  assign w_accept   = bus.ev_valid && w_ready;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (w_emit),
    .expired (w_expired)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TX_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and emit decode: a toggle is issued whenever no hold window
  // is running (IDLE, or HOLD with the timer expired) and work is pending.
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (w_has_pend) begin
          w_emit      = 1'b1;
          w_state_nxt = TX_HOLD;
        end
      end
      TX_HOLD: begin
        if (w_expired) begin
          if (w_has_pend) begin
            w_emit = 1'b1;
          end else begin
            w_state_nxt = TX_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = TX_IDLE;
      end
    endcase
  end

  // Pending counter: accept and emit at the same edge cancel out. Accept is
  // gated by ready and emit by nonzero, so the counter can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      case ({w_accept, w_emit})
        2'b10:   r_pending <= r_pending + PEND_W'(1);
        2'b01:   r_pending <= r_pending - PEND_W'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  // Encoded level line: one toggle per emitted event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= 1'b0;
    end else if (w_emit) begin
      r_sig <= ~r_sig;
    end
  end

  assign bus.ev_ready = w_ready;
  assign bus.sig_out  = r_sig;
  assign bus.pending  = r_pending;
  assign bus.busy     = (r_state != TX_IDLE) || w_has_pend;

endmodule : toggle_event_tx
`default_nettype wire

// File: tb/tb_toggle_event_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_toggle_event_tx
// Purpose  : Directed bench for toggle_event_tx with three parameter sets:
//            A (HOLD=4, PEND_W=4), B (HOLD=4, PEND_W=2), C (HOLD=1, PEND_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_event_tx;

  logic clk;
  logic rst;

  toggle_event_tx_if #(.PEND_W(4)) ifa ();
  toggle_event_tx_if #(.PEND_W(2)) ifb ();
  toggle_event_tx_if #(.PEND_W(4)) ifc ();

  toggle_event_tx #(.HOLD_CYCLES(4), .PEND_W(4)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  toggle_event_tx #(.HOLD_CYCLES(4), .PEND_W(2)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));
  toggle_event_tx #(.HOLD_CYCLES(1), .PEND_W(4)) u_dut_c (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Per-DUT observation: toggles, accepts, peak pending, toggle edge numbers.
  int   tA, tB, tC;
  int   aA, aB, aC;
  int   mA, mB, mC;
  logic pA, pB, pC;
  int   qA[$];
  int   qC[$];
  int   ready_while_full_b;
  int   seen_not_ready_b;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    if (!rst && ifa.ev_valid && ifa.ev_ready) aA++;
    if (!rst && ifb.ev_valid && ifb.ev_ready) aB++;
    if (!rst && ifc.ev_valid && ifc.ev_ready) aC++;
    @(posedge clk);
    #1;
    cyc++;
    if (ifa.sig_out !== pA) begin tA++; qA.push_back(cyc); end
    if (ifb.sig_out !== pB) tB++;
    if (ifc.sig_out !== pC) begin tC++; qC.push_back(cyc); end
    pA = ifa.sig_out;
    pB = ifb.sig_out;
    pC = ifc.sig_out;
    if (int'(ifa.pending) > mA) mA = int'(ifa.pending);
    if (int'(ifb.pending) > mB) mB = int'(ifb.pending);
    if (int'(ifc.pending) > mC) mC = int'(ifc.pending);
    if (ifb.pending == 2'd3 && ifb.ev_ready) ready_while_full_b++;
    if (!ifb.ev_ready) seen_not_ready_b = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int n;
    int bad_sp;
    tA = 0; tB = 0; tC = 0; aA = 0; aB = 0; aC = 0; mA = 0; mB = 0; mC = 0;
    pA = 1'b0; pB = 1'b0; pC = 1'b0;
    ready_while_full_b = 0; seen_not_ready_b = 0;

    // Reset held 3 cycles with ev_valid asserted: nothing accepted or toggled.
    rst = 1'b1;
    ifa.ev_valid = 1'b1; ifb.ev_valid = 1'b1; ifc.ev_valid = 1'b1;
    repeat (3) tick();
    chk_val("rst_sig_a",   32'(ifa.sig_out),  0);
    chk_val("rst_pend_a",  32'(ifa.pending),  0);
    chk_val("rst_ready_a", 32'(ifa.ev_ready), 1);
    chk_val("rst_busy_a",  32'(ifa.busy),     0);
    chk_val("rst_pend_b",  32'(ifb.pending),  0);
    chk_val("rst_pend_c",  32'(ifc.pending),  0);
    chk_val("rst_toggles", 32'(tA + tB + tC), 0);

    rst = 1'b0;
    ifa.ev_valid = 1'b0; ifb.ev_valid = 1'b0; ifc.ev_valid = 1'b0;
    repeat (2) tick();
    chk_val("idle_after_rst_a", 32'(ifa.sig_out), 0);

    // Single event: toggle one edge after accept, busy for HOLD_CYCLES more.
    tA = 0;
    ifa.ev_valid = 1'b1;
    tick();
    ifa.ev_valid = 1'b0;
    chk_val("single_pend_acc", 32'(ifa.pending), 1);
    chk_val("single_busy_acc", 32'(ifa.busy),    1);
    chk_val("single_sig_acc",  32'(ifa.sig_out), 0);
    tick();
    chk_val("single_sig_tog",  32'(ifa.sig_out), 1);
    chk_val("single_pend_tog", 32'(ifa.pending), 0);
    repeat (3) begin
      tick();
      chk_val("single_busy_hold", 32'(ifa.busy), 1);
    end
    tick();
    chk_val("single_busy_fall", 32'(ifa.busy), 0);
    repeat (5) tick();
    chk_val("single_toggles", 32'(tA), 1);

    // Five back-to-back events on A: toggles at b+2, +6, +10, +14, +18.
    tA = 0; aA = 0; mA = 0; qA.delete();
    b = cyc;
    ifa.ev_valid = 1'b1;
    repeat (5) tick();
    ifa.ev_valid = 1'b0;
    n = 0;
    while (ifa.busy && n < 40) begin tick(); n++; end
    chk_val("burst_drain_timeout", 32'(n < 40), 1);
    chk_val("burst_busy_fall_cyc", 32'(cyc - b), 22);
    chk_val("burst_accepts",  32'(aA), 5);
    chk_val("burst_toggles",  32'(tA), 5);
    chk_val("burst_peak_pend", 32'(mA), 4);
    chk_val("burst_final_sig", 32'(ifa.sig_out), 0);
    chk_val("burst_first_lat", 32'((qA.size() > 0) ? qA[0] - b : -1), 2);
    bad_sp = 0;
    for (int i = 1; i < qA.size(); i++) if (qA[i] - qA[i-1] != 4) bad_sp++;
    chk_val("burst_spacing_errs", 32'(bad_sp), 0);

    // Small counter on B: ten valid cycles saturate pending at 3.
    tB = 0; aB = 0; mB = 0; ready_while_full_b = 0; seen_not_ready_b = 0;
    ifb.ev_valid = 1'b1;
    repeat (10) tick();
    ifb.ev_valid = 1'b0;
    n = 0;
    while (ifb.busy && n < 40) begin tick(); n++; end
    chk_val("sat_drain_timeout", 32'(n < 40), 1);
    chk_val("sat_peak_pend",  32'(mB), 3);
    chk_val("sat_accepts",    32'(aB), 5);
    chk_val("sat_toggles",    32'(tB), 5);
    chk_val("sat_ready_full", 32'(ready_while_full_b), 0);
    chk_val("sat_ready_drop", 32'(seen_not_ready_b), 1);

    // HOLD_CYCLES=1 on C: one toggle per cycle, pending never above 1.
    tC = 0; aC = 0; mC = 0; qC.delete();
    ifc.ev_valid = 1'b1;
    repeat (8) tick();
    ifc.ev_valid = 1'b0;
    n = 0;
    while (ifc.busy && n < 20) begin tick(); n++; end
    chk_val("h1_drain_timeout", 32'(n < 20), 1);
    chk_val("h1_peak_pend", 32'(mC), 1);
    chk_val("h1_accepts",   32'(aC), 8);
    chk_val("h1_toggles",   32'(tC), 8);
    chk_val("h1_final_sig", 32'(ifc.sig_out), 0);
    bad_sp = 0;
    for (int i = 1; i < qC.size(); i++) if (qC[i] - qC[i-1] != 1) bad_sp++;
    chk_val("h1_spacing_errs", 32'(bad_sp), 0);

    // Reset in mid-operation on A with pending=3 and sig_out=1.
    ifa.ev_valid = 1'b1;
    repeat (4) tick();
    ifa.ev_valid = 1'b0;
    chk_val("mid_pend_before", 32'(ifa.pending), 3);
    chk_val("mid_sig_before",  32'(ifa.sig_out), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_val("mid_rst_sig",   32'(ifa.sig_out),  0);
    chk_val("mid_rst_pend",  32'(ifa.pending),  0);
    chk_val("mid_rst_busy",  32'(ifa.busy),     0);
    chk_val("mid_rst_ready", 32'(ifa.ev_ready), 1);
    tA = 0;
    repeat (6) tick();
    chk_val("mid_no_toggles", 32'(tA), 0);
    ifa.ev_valid = 1'b1;
    tick();
    ifa.ev_valid = 1'b0;
    tick();
    chk_val("mid_recover_sig", 32'(ifa.sig_out), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_toggle_event_tx
`default_nettype wire
